// File: rtl/e203_exu_disp_scbd.sv
// In-order outstanding-instruction scoreboard (OITF) beside EXU dispatch.
// Optional macro E203_SCBD_RET_BYPASS_EN: a retiring entry stops matching in its retire cycle.

`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_exu_disp_scbd #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         dis_ena,
    output logic                         dis_ready,
    output logic [PTR_W-1:0]             dis_ptr,

    input  logic                         disp_oitf_rs1en,
    input  logic                         disp_oitf_rs2en,
    input  logic                         disp_oitf_rs3en,
    input  logic                         disp_oitf_rs1fpu,
    input  logic                         disp_oitf_rs2fpu,
    input  logic                         disp_oitf_rs3fpu,
    input  logic [`E203_RFIDX_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [`E203_RFIDX_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [`E203_RFIDX_WIDTH-1:0] disp_oitf_rs3idx,
    input  logic                         disp_oitf_rdwen,
    input  logic                         disp_oitf_rdfpu,
    input  logic [`E203_RFIDX_WIDTH-1:0] disp_oitf_rdidx,
    input  logic [`E203_PC_SIZE-1:0]     disp_oitf_pc,

    output logic                         oitfrd_match_disprs1,
    output logic                         oitfrd_match_disprs2,
    output logic                         oitfrd_match_disprs3,
    output logic                         oitfrd_match_disprd,

    input  logic                         ret_ena,
    output logic [PTR_W-1:0]             ret_ptr,
    output logic [`E203_RFIDX_WIDTH-1:0] ret_rdidx,
    output logic                         ret_rdwen,
    output logic                         ret_rdfpu,
    output logic [`E203_PC_SIZE-1:0]     ret_pc,

    output logic                         oitf_empty
);

    logic [PTR_W-1:0]             wptr_q, wptr_d;
    logic [PTR_W-1:0]             rptr_q, rptr_d;
    logic                         wflg_q, wflg_d;
    logic                         rflg_q, rflg_d;
    logic [DEPTH-1:0]             valid_q, valid_d;

    logic                         rdwen_q [DEPTH];
    logic                         rdwen_d [DEPTH];
    logic                         rdfpu_q [DEPTH];
    logic                         rdfpu_d [DEPTH];
    logic [`E203_RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic [`E203_RFIDX_WIDTH-1:0] rdidx_d [DEPTH];
    logic [`E203_PC_SIZE-1:0]     pc_q    [DEPTH];
    logic [`E203_PC_SIZE-1:0]     pc_d    [DEPTH];

    logic full;
    logic empty;
    logic alloc_fire;
    logic ret_fire;

    assign empty = (wptr_q == rptr_q) && (wflg_q == rflg_q);
    assign full  = (wptr_q == rptr_q) && (wflg_q != rflg_q);

    assign dis_ready  = ~full;
    assign oitf_empty = empty;
    assign dis_ptr    = wptr_q;
    assign ret_ptr    = rptr_q;

    assign alloc_fire = dis_ena & ~full;
    assign ret_fire   = ret_ena & ~empty;

    assign ret_rdidx = rdidx_q[rptr_q];
    assign ret_rdwen = rdwen_q[rptr_q];
    assign ret_rdfpu = rdfpu_q[rptr_q];
    assign ret_pc    = pc_q[rptr_q];

    // Pointers wrap naturally at DEPTH (power of two); the flag toggles on that wrap.
    always_comb begin
        wptr_d = wptr_q;
        wflg_d = wflg_q;
        rptr_d = rptr_q;
        rflg_d = rflg_q;
        if (alloc_fire) begin
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == PTR_W'(DEPTH - 1)) begin
                wflg_d = ~wflg_q;
            end
        end
        if (ret_fire) begin
            rptr_d = rptr_q + 1'b1;
            if (rptr_q == PTR_W'(DEPTH - 1)) begin
                rflg_d = ~rflg_q;
            end
        end
    end

    // Allocate and retire never target the same entry: alloc needs not-full, retire needs not-empty.
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdwen_d[i] = rdwen_q[i];
            rdfpu_d[i] = rdfpu_q[i];
            rdidx_d[i] = rdidx_q[i];
            pc_d[i]    = pc_q[i];
        end
        if (ret_fire) begin
            valid_d[rptr_q] = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[wptr_q] = 1'b1;
            rdwen_d[wptr_q] = disp_oitf_rdwen;
            rdfpu_d[wptr_q] = disp_oitf_rdfpu;
            rdidx_d[wptr_q] = disp_oitf_rdidx;
            pc_d[wptr_q]    = disp_oitf_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            wflg_q  <= 1'b0;
            rflg_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            wflg_q  <= wflg_d;
            rflg_q  <= rflg_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdwen_q[i] <= rdwen_d[i];
            rdfpu_q[i] <= rdfpu_d[i];
            rdidx_q[i] <= rdidx_d[i];
            pc_q[i]    <= pc_d[i];
        end
    end

    always_comb begin
        logic live;
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprs3 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        live                 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live = valid_q[i] & rdwen_q[i];
`ifdef E203_SCBD_RET_BYPASS_EN
            if ((PTR_W'(i) == rptr_q) && ret_ena) begin
                live = 1'b0;
            end
`endif
            if (live && disp_oitf_rs1en && (rdidx_q[i] == disp_oitf_rs1idx)
                    && (rdfpu_q[i] == disp_oitf_rs1fpu)) begin
                oitfrd_match_disprs1 = 1'b1;
            end
            if (live && disp_oitf_rs2en && (rdidx_q[i] == disp_oitf_rs2idx)
                    && (rdfpu_q[i] == disp_oitf_rs2fpu)) begin
                oitfrd_match_disprs2 = 1'b1;
            end
            if (live && disp_oitf_rs3en && (rdidx_q[i] == disp_oitf_rs3idx)
                    && (rdfpu_q[i] == disp_oitf_rs3fpu)) begin
                oitfrd_match_disprs3 = 1'b1;
            end
            if (live && disp_oitf_rdwen && (rdidx_q[i] == disp_oitf_rdidx)
                    && (rdfpu_q[i] == disp_oitf_rdfpu)) begin
                oitfrd_match_disprd = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_disp_scbd.sv
// Self-checking bench for e203_exu_disp_scbd (DEPTH=2) with an in-order retire scoreboard.

`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module tb_e203_exu_disp_scbd;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    typedef struct {
        logic [`E203_RFIDX_WIDTH-1:0] rd;
        logic [`E203_PC_SIZE-1:0]     pc;
    } ent_t;

    logic                         clk;
    logic                         rst_n;
    logic                         dis_ena;
    logic                         dis_ready;
    logic [PTR_W-1:0]             dis_ptr;
    logic                         rs1en, rs2en, rs3en;
    logic                         rs1fpu, rs2fpu, rs3fpu;
    logic [`E203_RFIDX_WIDTH-1:0] rs1idx, rs2idx, rs3idx;
    logic                         rdwen, rdfpu;
    logic [`E203_RFIDX_WIDTH-1:0] rdidx;
    logic [`E203_PC_SIZE-1:0]     pc;
    logic                         m_rs1, m_rs2, m_rs3, m_rd;
    logic                         ret_ena;
    logic [PTR_W-1:0]             ret_ptr;
    logic [`E203_RFIDX_WIDTH-1:0] ret_rdidx;
    logic                         ret_rdwen, ret_rdfpu;
    logic [`E203_PC_SIZE-1:0]     ret_pc;
    logic                         oitf_empty;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];
    int   occ = 0;
    int   mw  = 0;
    int   mr  = 0;

    e203_exu_disp_scbd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dis_ena              (dis_ena),
        .dis_ready            (dis_ready),
        .dis_ptr              (dis_ptr),
        .disp_oitf_rs1en      (rs1en),
        .disp_oitf_rs2en      (rs2en),
        .disp_oitf_rs3en      (rs3en),
        .disp_oitf_rs1fpu     (rs1fpu),
        .disp_oitf_rs2fpu     (rs2fpu),
        .disp_oitf_rs3fpu     (rs3fpu),
        .disp_oitf_rs1idx     (rs1idx),
        .disp_oitf_rs2idx     (rs2idx),
        .disp_oitf_rs3idx     (rs3idx),
        .disp_oitf_rdwen      (rdwen),
        .disp_oitf_rdfpu      (rdfpu),
        .disp_oitf_rdidx      (rdidx),
        .disp_oitf_pc         (pc),
        .oitfrd_match_disprs1 (m_rs1),
        .oitfrd_match_disprs2 (m_rs2),
        .oitfrd_match_disprs3 (m_rs3),
        .oitfrd_match_disprd  (m_rd),
        .ret_ena              (ret_ena),
        .ret_ptr              (ret_ptr),
        .ret_rdidx            (ret_rdidx),
        .ret_rdwen            (ret_rdwen),
        .ret_rdfpu            (ret_rdfpu),
        .ret_pc               (ret_pc),
        .oitf_empty           (oitf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock with the given enables; the model follows the same fire rules.
    task automatic tick(input logic d, input logic r);
        bit fa;
        bit fr;
        ent_t e;
        dis_ena = d;
        ret_ena = r;
        fa = d && (occ < DEPTH);
        fr = r && (occ > 0);
        if (fr) begin
            void'(sb.pop_front());
            mr = (mr + 1) % DEPTH;
            occ--;
        end
        if (fa) begin
            e.rd = rdidx;
            e.pc = pc;
            sb.push_back(e);
            mw = (mw + 1) % DEPTH;
            occ++;
        end
        @(posedge clk);
        #1;
        dis_ena = 1'b0;
        ret_ena = 1'b0;
    endtask

    task automatic set_dest(input int rd, input int p);
        rdwen = 1'b1;
        rdfpu = 1'b0;
        rdidx = rd[`E203_RFIDX_WIDTH-1:0];
        pc    = p;
    endtask

    task automatic clear_srcs();
        rs1en = 1'b0; rs2en = 1'b0; rs3en = 1'b0;
        rs1fpu = 1'b0; rs2fpu = 1'b0; rs3fpu = 1'b0;
        rs1idx = '0; rs2idx = '0; rs3idx = '0;
        rdwen = 1'b0; rdfpu = 1'b0; rdidx = '0; pc = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rs1en = 1'b1; rs1idx = '0;
        rdwen = 1'b1; rdidx = '0;
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", oitf_empty); end
        checks++; if (dis_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dis_ready); end
        checks++; if (dis_ptr !== 1'b0) begin errors++; $display("FAIL reset_dis_ptr got=%0d exp=0", dis_ptr); end
        checks++; if (ret_ptr !== 1'b0) begin errors++; $display("FAIL reset_ret_ptr got=%0d exp=0", ret_ptr); end
        checks++; if ({m_rs1, m_rs2, m_rs3, m_rd} !== 4'b0000) begin
            errors++; $display("FAIL reset_match got=%b exp=0000", {m_rs1, m_rs2, m_rs3, m_rd});
        end
        clear_srcs();
    endtask

    task automatic test_fill();
        set_dest(5, 32'h100); tick(1'b1, 1'b0);
        set_dest(6, 32'h104); tick(1'b1, 1'b0);
        clear_srcs();
        rs1en = 1'b1; rs1idx = 5'd5; rs1fpu = 1'b0;
        rs2en = 1'b1; rs2idx = 5'd6; rs2fpu = 1'b1;
        rs3en = 1'b1; rs3idx = 5'd6; rs3fpu = 1'b0;
        rdwen = 1'b1; rdidx = 5'd9;
        #1;
        checks++; if (dis_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", dis_ready); end
        checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", oitf_empty); end
        checks++; if (m_rs1 !== 1'b1) begin errors++; $display("FAIL fill_rs1_match got=%b exp=1", m_rs1); end
        checks++; if (m_rs2 !== 1'b0) begin errors++; $display("FAIL fill_rs2_fpu_match got=%b exp=0", m_rs2); end
        checks++; if (m_rs3 !== 1'b1) begin errors++; $display("FAIL fill_rs3_match got=%b exp=1", m_rs3); end
        checks++; if (m_rd !== 1'b0) begin errors++; $display("FAIL fill_rd_match got=%b exp=0", m_rd); end
        rdidx = 5'd6;
        #1;
        checks++; if (m_rd !== 1'b1) begin errors++; $display("FAIL fill_waw_match got=%b exp=1", m_rd); end
        clear_srcs();
    endtask

    task automatic test_full_ignore();
        set_dest(9, 32'h200);
        tick(1'b1, 1'b0);
        clear_srcs();
        checks++; if (dis_ptr !== PTR_W'(mw)) begin errors++; $display("FAIL full_dis_ptr got=%0d exp=%0d", dis_ptr, mw); end
        checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL full_ret_rd got=%0d exp=%0d", ret_rdidx, sb[0].rd); end
        checks++; if (ret_pc !== sb[0].pc) begin errors++; $display("FAIL full_ret_pc got=%h exp=%h", ret_pc, sb[0].pc); end
        checks++; if (dis_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", dis_ready); end
        repeat (2) begin
            checks++; if (ret_ptr !== PTR_W'(mr)) begin errors++; $display("FAIL drain_ret_ptr got=%0d exp=%0d", ret_ptr, mr); end
            checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL drain_ret_rd got=%0d exp=%0d", ret_rdidx, sb[0].rd); end
            tick(1'b0, 1'b1);
        end
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_wrap();
        logic [PTR_W-1:0] seq [5];
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            set_dest(10 + k, 32'h300 + 4 * k);
            tick(1'b1, 1'b0);
            clear_srcs();
            checks++; if (ret_ptr !== seq[k]) begin errors++; $display("FAIL wrap_ret_ptr[%0d] got=%0d exp=%0d", k, ret_ptr, seq[k]); end
            checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL wrap_ret_rd[%0d] got=%0d exp=%0d", k, ret_rdidx, sb[0].rd); end
            tick(1'b0, 1'b1);
        end
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_simultaneous();
        set_dest(20, 32'h400); tick(1'b1, 1'b0);
        checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL simul_pre_rd got=%0d exp=%0d", ret_rdidx, sb[0].rd); end
        set_dest(21, 32'h404); tick(1'b1, 1'b1);
        clear_srcs();
        checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL simul_empty got=%b exp=0", oitf_empty); end
        checks++; if (dis_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got=%b exp=1", dis_ready); end
        checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL simul_ret_rd got=%0d exp=%0d", ret_rdidx, sb[0].rd); end
        checks++; if (ret_pc !== sb[0].pc) begin errors++; $display("FAIL simul_ret_pc got=%h exp=%h", ret_pc, sb[0].pc); end
        tick(1'b0, 1'b1);
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL simul_drain got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_bypass();
        logic exp_byp;
`ifdef E203_SCBD_RET_BYPASS_EN
        exp_byp = 1'b0;
`else
        exp_byp = 1'b1;
`endif
        set_dest(7, 32'h500); tick(1'b1, 1'b0);
        clear_srcs();
        rs1en = 1'b1; rs1idx = 5'd7;
        #1;
        checks++; if (m_rs1 !== 1'b1) begin errors++; $display("FAIL byp_idle_match got=%b exp=1", m_rs1); end
        ret_ena = 1'b1;
        #1;
        checks++; if (m_rs1 !== exp_byp) begin errors++; $display("FAIL byp_ret_match got=%b exp=%b", m_rs1, exp_byp); end
        checks++; if (dis_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got=%b exp=1", dis_ready); end
        tick(1'b0, 1'b1);
        checks++; if (m_rs1 !== 1'b0) begin errors++; $display("FAIL byp_after_match got=%b exp=0", m_rs1); end
        clear_srcs();
    endtask

    task automatic test_ret_empty();
        tick(1'b0, 1'b1);
        checks++; if (ret_ptr !== PTR_W'(mr)) begin errors++; $display("FAIL retempty_ret_ptr got=%0d exp=%0d", ret_ptr, mr); end
        checks++; if (dis_ptr !== PTR_W'(mw)) begin errors++; $display("FAIL retempty_dis_ptr got=%0d exp=%0d", dis_ptr, mw); end
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL retempty_empty got=%b exp=1", oitf_empty); end
        set_dest(3, 32'h600); tick(1'b1, 1'b1);
        clear_srcs();
        checks++; if (oitf_empty !== 1'b0) begin errors++; $display("FAIL retempty_alloc_empty got=%b exp=0", oitf_empty); end
        checks++; if (ret_ptr !== PTR_W'(mr)) begin errors++; $display("FAIL retempty_alloc_rptr got=%0d exp=%0d", ret_ptr, mr); end
        checks++; if (ret_rdidx !== sb[0].rd) begin errors++; $display("FAIL retempty_alloc_rd got=%0d exp=%0d", ret_rdidx, sb[0].rd); end
    endtask

    task automatic test_async_reset();
        set_dest(12, 32'h700); tick(1'b1, 1'b0);
        clear_srcs();
        #2;
        rst_n = 1'b0;
        sb.delete();
        occ = 0; mw = 0; mr = 0;
        #1;
        rs1en = 1'b1; rs1idx = 5'd12;
        #1;
        checks++; if (oitf_empty !== 1'b1) begin errors++; $display("FAIL arst_empty got=%b exp=1", oitf_empty); end
        checks++; if (dis_ptr !== PTR_W'(mw)) begin errors++; $display("FAIL arst_dis_ptr got=%0d exp=%0d", dis_ptr, mw); end
        checks++; if (ret_ptr !== PTR_W'(mr)) begin errors++; $display("FAIL arst_ret_ptr got=%0d exp=%0d", ret_ptr, mr); end
        checks++; if (m_rs1 !== 1'b0) begin errors++; $display("FAIL arst_match got=%b exp=0", m_rs1); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_srcs();
    endtask

    initial begin
        rst_n   = 1'b0;
        dis_ena = 1'b0;
        ret_ena = 1'b0;
        clear_srcs();
        test_reset();
        test_fill();
        test_full_ignore();
        test_wrap();
        test_simultaneous();
        test_bypass();
        test_ret_empty();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
